// File: rtl/pwm_tone_monitor.sv
// pwm_tone_monitor: decodes a PWM/square-wave audio line into tone bursts.
// Measures tone half-period and counts completed beeps.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   pwm_in       audio line under observation (may be asynchronous)
//   clear        synchronous clear of beep_count
//   tone_active  high while a valid tone is being received
//   half_period  clocks between the last two edges of the current/last tone
//   period_valid one-cycle pulse when half_period updates
//   beep_count   completed beeps since reset/clear, saturating
//   beep_done    one-cycle pulse when a beep ends
module pwm_tone_monitor #(
  parameter int CNT_W          = 20,
  parameter int SILENCE_CYCLES = 100000,
  parameter int MIN_EDGES      = 4,
  parameter int BEEP_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  input  logic              clear,
  output logic              tone_active,
  output logic [CNT_W-1:0]  half_period,
  output logic              period_valid,
  output logic [BEEP_W-1:0] beep_count,
  output logic              beep_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    TONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SIL =
    CNT_W'(SILENCE_CYCLES);
  localparam logic [3:0] MIN_E = 4'(MIN_EDGES);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] gap_cnt;
  logic [3:0]       edge_cnt;

  logic             edge_det;
  logic             silent;
  logic [CNT_W-1:0] interval;
  logic [3:0]       edge_nxt;

  assign edge_det = sync2 ^ prev;
  // Silence is judged on the registered gap count.
  assign silent   = (gap_cnt >= SIL);
  // gap_cnt is cleared on an edge, so +1 gives the edge spacing.
  assign interval = gap_cnt + CNT_W'(1);
  assign edge_nxt = edge_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      gap_cnt      <= '0;
      edge_cnt     <= '0;
      state        <= IDLE;
      tone_active  <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      beep_count   <= '0;
      beep_done    <= 1'b0;
    end else begin
      sync1        <= pwm_in;
      sync2        <= sync1;
      prev         <= sync2;
      period_valid <= 1'b0;
      beep_done    <= 1'b0;

      if (edge_det)
        gap_cnt <= '0;
      else if (~&gap_cnt)
        gap_cnt <= gap_cnt + CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (edge_det) begin
            state    <= ARM;
            edge_cnt <= 4'd1;
          end
        end
        ARM: begin
          if (edge_det) begin
            edge_cnt <= edge_nxt;
            if (edge_nxt == MIN_E) begin
              state        <= TONE;
              tone_active  <= 1'b1;
              half_period  <= interval;
              period_valid <= 1'b1;
            end
          end else if (silent) begin
            // Too few edges: treat as a glitch.
            state    <= IDLE;
            edge_cnt <= '0;
          end
        end
        TONE: begin
          if (edge_det) begin
            half_period  <= interval;
            period_valid <= 1'b1;
          end else if (silent) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            tone_active <= 1'b0;
            beep_done   <= 1'b1;
            if (~&beep_count)
              beep_count <= beep_count + BEEP_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase

      // Placed last so a coincident clear overrides the increment.
      if (clear)
        beep_count <= '0;
    end
  end

endmodule

// File: tb/tb_pwm_tone_monitor.sv
// tb_pwm_tone_monitor: directed self-checking bench for pwm_tone_monitor.
// Small parameters keep tones and silence windows short.
module tb_pwm_tone_monitor;

  localparam int CNT_W  = 12;
  localparam int SIL    = 64;
  localparam int MIN_E  = 4;
  localparam int BEEP_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              pwm_in;
  logic              clear;
  logic              tone_active;
  logic [CNT_W-1:0]  half_period;
  logic              period_valid;
  logic [BEEP_W-1:0] beep_count;
  logic              beep_done;

  pwm_tone_monitor #(
    .CNT_W(CNT_W),
    .SILENCE_CYCLES(SIL),
    .MIN_EDGES(MIN_E),
    .BEEP_W(BEEP_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwm_in(pwm_in),
    .clear(clear),
    .tone_active(tone_active),
    .half_period(half_period),
    .period_valid(period_valid),
    .beep_count(beep_count),
    .beep_done(beep_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int pv_cnt = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic prev_tone = 1'b0;

  int t4;
  int t_last;

  always @(negedge clk) begin
    if (period_valid) pv_cnt++;
    if (beep_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tone_active && !prev_tone) begin
      rise_cyc = cyc;
      rise_cnt++;
    end
    if (!tone_active && prev_tone)
      fall_cyc = cyc;
    prev_tone = tone_active;
  end

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle pwm_in n times, half clocks apart.
  task automatic burst(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
      if (i == 3) t4 = cyc;
      t_last = cyc;
      if (i < n - 1) repeat (half - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int pv0;
  int d0;
  int r0;
  logic [1:0] st;

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    clear  = 1'b0;

    // 1. reset with a toggling line
    repeat (10) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    @(negedge clk);
    chk("rst_tone", int'(tone_active), 0);
    chk("rst_hp", int'(half_period), 0);
    chk("rst_cnt", int'(beep_count), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_done", int'(beep_done), 0);
    pwm_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pv0 = pv_cnt;
    r0  = rise_cnt;
    quiet(200);
    chk("idle_tone", int'(tone_active), 0);
    chk("idle_pv", pv_cnt - pv0, 0);
    chk("idle_rise", rise_cnt - r0, 0);
    chk("idle_cnt", int'(beep_count), 0);

    // 2. single tone
    pv0 = pv_cnt;
    d0  = done_cnt;
    burst(8, 10);
    quiet(100);
    chk("t2_rise_lat", rise_cyc - t4, 3);
    chk("t2_hp", int'(half_period), 10);
    chk("t2_pv", pv_cnt - pv0, 5);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_done_lat", done_cyc - t_last, 68);
    chk("t2_fall", fall_cyc, done_cyc);
    chk("t2_cnt", int'(beep_count), 1);
    chk("t2_tone", int'(tone_active), 0);

    pulse_clear();
    chk("clr_cnt", int'(beep_count), 0);

    // 3. glitch rejection
    pv0 = pv_cnt;
    d0  = done_cnt;
    r0  = rise_cnt;
    burst(3, 10);
    quiet(100);
    chk("t3_rise", rise_cnt - r0, 0);
    chk("t3_pv", pv_cnt - pv0, 0);
    chk("t3_done", done_cnt - d0, 0);
    chk("t3_cnt", int'(beep_count), 0);
    st = dut.state;
    chk("t3_state", int'(st), 0);

    // 4. five bursts, counter saturates at 3
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) begin
      burst(8, 20);
      quiet(150);
      chk("t4_cnt", int'(beep_count),
          (k < 3) ? k + 1 : 3);
      chk("t4_done", done_cnt - d0, k + 1);
    end
    chk("t4_hp", int'(half_period), 20);
    chk("t4_rise_lat", rise_cyc - t4, 3);

    // 5. clear coincident with beep_done
    burst(8, 20);
    repeat (67) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_done", int'(beep_done), 1);
    chk("t5_cnt", int'(beep_count), 0);
    quiet(100);
    burst(8, 20);
    quiet(100);
    chk("t5_cnt_after", int'(beep_count), 1);

    // 6. reset during an active tone
    burst(6, 20);
    quiet(5);
    chk("t6_pre_tone", int'(tone_active), 1);
    reset = 1'b1;
    #1;
    chk("t6_tone", int'(tone_active), 0);
    chk("t6_hp", int'(half_period), 0);
    chk("t6_cnt", int'(beep_count), 0);
    chk("t6_done", int'(beep_done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    quiet(150);
    chk("t6_no_done", done_cnt - d0, 0);
    burst(8, 15);
    quiet(100);
    chk("t6_cnt_new", int'(beep_count), 1);
    chk("t6_hp_new", int'(half_period), 15);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_tone_monitor.md
Name: pwm_tone_monitor

Overview:
- Receive-side counterpart to the sound PWM generators: samples a square-wave/PWM audio line and decodes it back into tone bursts ("beeps").
- Measures the tone half-period and counts completed beeps.
- Used for on-board self-check of the game-over and engine sound outputs, and as a hook for the debug display.
- Sits between a sound module's pwm output and the status/debug logic, in the same clock domain.

Parameters:
- CNT_W, 20, width of gap counter and half_period output.
- SILENCE_CYCLES, 100000, quiet clocks after the last edge that end a tone (must be < 2^CNT_W - 1).
- MIN_EDGES, 4, edges required before a burst is declared a tone (range 2..15).
- BEEP_W, 8, width of beep_count.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pwm_in  input  1  audio PWM line under observation (may be asynchronous)
- clear  input  1  synchronous; zeroes beep_count
- tone_active  output  1  high while a valid tone is being received
- half_period  output  CNT_W  clocks between the last two edges of the current/last tone
- period_valid  output  1  one-cycle pulse when half_period updates
- beep_count  output  BEEP_W  completed beeps since reset/clear, saturating
- beep_done  output  1  one-cycle pulse when a beep ends

Behaviour:
- Reset (async, active-high):
  - sync1, sync2 and prev flops = 0; gap_cnt = 0; edge_cnt = 0; state = IDLE.
  - All outputs = 0.
  - Reset asserted mid-tone aborts immediately; no beep_done and no count for the aborted tone.
- Input path:
  - Two-flop synchronizer (sync1 <= pwm_in, sync2 <= sync1), then prev <= sync2.
  - edge = sync2 ^ prev. Both rising and falling edges count.
  - A pwm_in change sampled at clock edge N raises edge in the cycle after edge N+1. Registered outputs react at edge N+2.
- gap_cnt:
  - Cleared to 0 on the clock where edge = 1.
  - Otherwise increments, saturating at all-ones.
  - interval = gap_cnt + 1 taken at an edge = clocks between consecutive edges.
- FSM, encoded in 2 bits:
  - IDLE:
    - edge -> ARM, edge_cnt = 1.
  - ARM:
    - edge -> edge_cnt + 1.
    - If edge_cnt + 1 == MIN_EDGES -> TONE: tone_active <= 1, half_period <= interval, period_valid pulse.
    - Else if no edge and gap_cnt >= SILENCE_CYCLES -> IDLE, edge_cnt = 0. This is a glitch: no count, no pulse.
  - TONE:
    - Each edge: half_period <= interval, period_valid pulse.
    - No edge and gap_cnt >= SILENCE_CYCLES -> IDLE:
      - tone_active <= 0, beep_done pulse.
      - beep_count <= beep_count + 1, saturating at all-ones.
      - edge_cnt = 0.
      - half_period holds its last value.
- Silence test uses the registered gap_cnt. Edge has priority over the silence timeout in the same cycle.
- clear:
  - beep_count <= 0 on the next edge.
  - If coincident with a beep_done increment, clear wins (beep_count = 0), but beep_done still pulses.
  - clear does not affect the FSM, half_period or tone_active.
- half_period is not updated in IDLE or for pre-tone ARM edges other than the transition edge.
- Constant-level pwm_in (stuck 0 or 1) never leaves IDLE.

Test Plan (SILENCE_CYCLES=64, MIN_EDGES=4, BEEP_W=2, CNT_W=12):
1. Reset:
   - Assert reset with pwm_in toggling -> all outputs 0.
   - Release, hold pwm_in=0 for 200 cycles -> outputs stay 0.
2. Single tone:
   - Square wave with 10-clock half-period, 8 edges, then 100 quiet cycles.
   - tone_active rises 2 clocks after the 4th pwm_in transition.
   - half_period = 10; period_valid pulses exactly 5 times.
   - beep_done pulses once, 64 clocks after the last edge's registered gap count.
   - beep_count = 1; tone_active falls in the same cycle as beep_done.
3. Glitch rejection:
   - 3 transitions, 10 clocks apart, then 100 quiet cycles.
   - tone_active never rises, period_valid never pulses, beep_count = 0, FSM returns to IDLE.
4. Game-over pattern with saturation:
   - 5 bursts (8 edges each, half-period 20) separated by 150 quiet cycles.
   - beep_done pulses 5 times; beep_count goes 1, 2, 3, 3, 3 (saturates).
5. clear collision:
   - clear asserted in the same cycle beep_done is generated -> beep_count = 0 the next cycle; beep_done still pulses.
   - A following burst -> beep_count = 1.
6. Mid-tone reset:
   - Assert reset for 3 cycles during an active tone -> outputs 0 immediately, with no beep_done.
   - A new burst after release -> beep_count = 1, half_period equals the new burst's spacing.
